// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards that forwarding cannot cover, kills wrong-path
// instructions on an execute redirect, and freezes the pipe while a data
// memory access is outstanding. If the access never completes, the block
// falls into a sticky error state that only reset clears.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_cnt performance counters. Without it those ports do not exist and the
// control behaviour is unchanged.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] de_rs1,
  input  logic [4:0] de_rs2,
  input  logic       de_rs1_used,
  input  logic       de_rs2_used,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       pc_r,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       fe_stall,
  output logic       fe_flush,
  output logic       ex_bubble,
  output logic       ex_stall,
  output logic       mem_stall,
  output logic       wb_bubble,
  output logic       err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // The wait counter must be able to hold MEM_TIMEOUT.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  // Reject configurations that cannot work: the timeout needs at least
  // one MEM_WAIT cycle, and the counters need at least one bit.
  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_ctrl: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic loadUse;
  logic memMiss;
  logic timeoutHit;

  // Hazard detection. A load into x0 never creates a dependency, and a
  // source register only matters when decode actually reads it.
  always_comb begin
    loadUse = 1'b0;
    if (ex_mem_read && (ex_rd != 5'd0)) begin
      loadUse = (de_rs1_used && (de_rs1 == ex_rd)) ||
                (de_rs2_used && (de_rs2 == ex_rd));
    end
  end

  // An access that does not complete in the same cycle is a miss. The last
  // allowed wait cycle is MEM_TIMEOUT-1 because the RUN cycle that started
  // the access already counts as the first stalled cycle.
  always_comb begin
    memMiss    = dmem_req && !dmem_ready;
    timeoutHit = (cnt_q == CW'(MEM_TIMEOUT - 1));
  end

  // State and wait counter, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-stage enables. Outputs act in the same cycle, and
  // all of them are forced low while reset is asserted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fe_stall  = 1'b0;
    fe_flush  = 1'b0;
    ex_bubble = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    wb_bubble = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (memMiss) begin
          fe_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
          state_d   = MEM_WAIT;
          cnt_d     = CW'(1);
        end else if (pc_r) begin
          // The instruction in decode is on the wrong path. Its load-use
          // hazard is irrelevant, and the PC must be free to take the target.
          fe_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (loadUse) begin
          // A single bubble is enough. Next cycle the load is in MEM and the
          // writeback forwarding path covers the dependency.
          fe_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready) begin
          // Release cycle. Execute was frozen, so redirect and load-use
          // are evaluated now, exactly as they would be in RUN.
          if (pc_r) begin
            fe_flush  = 1'b1;
            ex_bubble = 1'b1;
          end else if (loadUse) begin
            fe_stall  = 1'b1;
            ex_bubble = 1'b1;
          end
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          fe_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
          if (timeoutHit) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ERR: begin
        fe_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        wb_bubble = 1'b1;
        err       = 1'b1;
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      fe_stall  = 1'b0;
      fe_flush  = 1'b0;
      ex_bubble = 1'b0;
      ex_stall  = 1'b0;
      mem_stall = 1'b0;
      wb_bubble = 1'b0;
      err       = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Performance counters. Each one counts the cycles in which fetch was held
  // or flushed, and wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      if (fe_stall) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
      if (fe_flush) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl.
// The driver applies one stimulus per cycle, #1 after the rising edge, and
// pushes the response predicted by a behavioural model. The monitor pops
// that prediction on every falling edge and compares it with the DUT outputs.
module tb_pipe_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] de_rs1 = '0;
  logic [4:0] de_rs2 = '0;
  logic       de_rs1_used = 1'b0;
  logic       de_rs2_used = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       pc_r = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       fe_stall, fe_flush, ex_bubble, ex_stall, mem_stall, wb_bubble, err;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_cnt;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .pc_r(pc_r), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fe_stall(fe_stall), .fe_flush(fe_flush), .ex_bubble(ex_bubble),
    .ex_stall(ex_stall), .mem_stall(mem_stall), .wb_bubble(wb_bubble),
    .err(err)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1Used;
    logic       rs2Used;
    logic       memRead;
    logic [4:0] rd;
    logic       pcR;
    logic       req;
    logic       ready;
  } stim_t;

  // Output vector order: fe_stall fe_flush ex_bubble ex_stall mem_stall wb_bubble err
  typedef struct packed {
    logic [6:0]       outs;
    logic [CNT_W-1:0] stalls;
    logic [CNT_W-1:0] flushes;
  } exp_t;

  localparam logic [6:0] NONE     = 7'b0000000;
  localparam logic [6:0] FREEZE   = 7'b1001110;
  localparam logic [6:0] FROZEN_E = 7'b1001111;
  localparam logic [6:0] REDIRECT = 7'b0110000;
  localparam logic [6:0] LOADUSE  = 7'b1010000;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Reference model state. It tracks whether an access is outstanding, how
  // many cycles in a row it has gone unanswered, and whether the error is latched.
  bit               accessOpen = 1'b0;
  int               missRun    = 0;
  bit               errSeen    = 1'b0;
  logic [CNT_W-1:0] stallTotal = '0;
  logic [CNT_W-1:0] flushTotal = '0;

  // Predict the outputs for one cycle of stimulus, then advance the model.
  function automatic exp_t modelStep(input stim_t s);
    exp_t       e;
    logic [6:0] pipeOuts;
    logic [6:0] o;
    bit         lu;
    e = '0;
    if (s.rst) begin
      accessOpen = 1'b0;
      missRun    = 0;
      errSeen    = 1'b0;
      stallTotal = '0;
      flushTotal = '0;
      return e;
    end
    lu = s.memRead && (s.rd != 5'd0) &&
         ((s.rs1Used && s.rs1 == s.rd) || (s.rs2Used && s.rs2 == s.rd));
    if (s.pcR)   pipeOuts = REDIRECT;
    else if (lu) pipeOuts = LOADUSE;
    else         pipeOuts = NONE;

    if (errSeen) begin
      o = FROZEN_E;
    end else if (accessOpen) begin
      if (s.ready) begin
        o = pipeOuts;
        accessOpen = 1'b0;
        missRun = 0;
      end else begin
        o = FREEZE;
        missRun++;
        if (missRun >= MEM_TIMEOUT) errSeen = 1'b1;
      end
    end else if (s.req && !s.ready) begin
      o = FREEZE;
      accessOpen = 1'b1;
      missRun = 1;
    end else begin
      o = pipeOuts;
    end
    e.outs    = o;
    e.stalls  = stallTotal;
    e.flushes = flushTotal;
    stallTotal = stallTotal + CNT_W'(o[6]);
    flushTotal = flushTotal + CNT_W'(o[5]);
    return e;
  endfunction

  // Drive one cycle of stimulus and record the predicted response.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    reset       = s.rst;
    de_rs1      = s.rs1;
    de_rs2      = s.rs2;
    de_rs1_used = s.rs1Used;
    de_rs2_used = s.rs2Used;
    ex_mem_read = s.memRead;
    ex_rd       = s.rd;
    pc_r        = s.pcR;
    dmem_req    = s.req;
    dmem_ready  = s.ready;
    expQ.push_back(modelStep(s));
  endtask

  // Pop the oldest prediction and compare it against the live DUT outputs.
  task automatic checkOutput();
    exp_t       e;
    logic [6:0] act;
    act = {fe_stall, fe_flush, ex_bubble, ex_stall, mem_stall, wb_bubble, err};
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_empty at %0t: got outputs %b, required a queued prediction", $time, act);
      return;
    end
    e = expQ.pop_front();
    if (act !== e.outs) begin
      testsFailed++;
      $display("[TB] FAIL outputs at %0t: got %b required %b", $time, act, e.outs);
    end
`ifdef PIPE_CTRL_PERF_EN
    testsRun++;
    if (stall_cycles !== e.stalls) begin
      testsFailed++;
      $display("[TB] FAIL stall_cycles at %0t: got %0d required %0d", $time, stall_cycles, e.stalls);
    end
    testsRun++;
    if (flush_cnt !== e.flushes) begin
      testsFailed++;
      $display("[TB] FAIL flush_cnt at %0t: got %0d required %0d", $time, flush_cnt, e.flushes);
    end
`endif
  endtask

  // Monitor: one comparison per cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // lw x5 in EX, add x6,x5,x1 in decode: one bubble, then clear.
    s = idle(); s.memRead = 1'b1; s.rd = 5'd5;
    s.rs1 = 5'd5; s.rs1Used = 1'b1; s.rs2 = 5'd1; s.rs2Used = 1'b1;
    applyStimulus(s);
    s.memRead = 1'b0; s.rd = 5'd0;
    applyStimulus(s);

    // A load into x0 never stalls.
    s = idle(); s.memRead = 1'b1; s.rd = 5'd0; s.rs1Used = 1'b1; s.rs2Used = 1'b1;
    applyStimulus(s);

    // rs2 matches but is unused: no stall. Once rs2 is used: stall.
    s = idle(); s.memRead = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.rs1 = 5'd3; s.rs1Used = 1'b1;
    applyStimulus(s);
    s.rs2Used = 1'b1;
    applyStimulus(s);

    // Redirect together with load-use: flush only.
    s.pcR = 1'b1;
    applyStimulus(s);

    // Memory wait: not ready for three cycles, released on the fourth.
    s = idle(); s.req = 1'b1;
    repeat (3) applyStimulus(s);
    s.ready = 1'b1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Redirect and load-use are suppressed while frozen, and the redirect acts on release.
    s = idle(); s.req = 1'b1; s.pcR = 1'b1; s.memRead = 1'b1; s.rd = 5'd2;
    s.rs1 = 5'd2; s.rs1Used = 1'b1;
    repeat (3) applyStimulus(s);
    s.ready = 1'b1;
    applyStimulus(s);
    s = idle(); s.memRead = 1'b1; s.rd = 5'd4; s.rs2 = 5'd4; s.rs2Used = 1'b1; s.req = 1'b1;
    s.ready = 1'b1;
    applyStimulus(s);

    // Reset asserted in the middle of a wait, then the pipe resumes in RUN.
    s = idle(); s.req = 1'b1;
    repeat (5) applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    s = idle(); s.memRead = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9; s.rs1Used = 1'b1;
    applyStimulus(s);

    // Memory never answers: the error latches and holds until reset.
    s = idle(); s.req = 1'b1;
    repeat (MEM_TIMEOUT + 4) applyStimulus(s);
    s.ready = 1'b1; s.pcR = 1'b1;
    applyStimulus(s);
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Randomized traffic over a small register set, so that hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst     = ($urandom_range(0, 63) == 0);
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rs1Used = 1'($urandom_range(0, 1));
      s.rs2Used = 1'($urandom_range(0, 1));
      s.memRead = 1'($urandom_range(0, 1));
      s.rd      = 5'($urandom_range(0, 3));
      s.pcR     = ($urandom_range(0, 4) == 0);
      s.req     = ($urandom_range(0, 3) == 0);
      s.ready   = ($urandom_range(0, 9) < 6);
      applyStimulus(s);
    end

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover predictions, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
